mem_arbiter: RTL and testbench

Shares one single-port data/instruction memory between the instruction-fetch port and the load/store port of the pipeline. Arbitrates, sequences one outstanding transaction at a time, and handles sub-word lanes:
- byte-enable generation and write-data replication on stores;
- lane extraction and sign/zero extension on loads.

Sits between the core's IF/MA stages and the memory macro, replacing the separate per-stage memories.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_lane.sv | 76 +++++++
 rtl/mem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and codes for the mem_arbiter slice: FSM states, access
// width codes and transaction owner codes.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Word-aligned form of a byte address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Sub-word lane handling between the data port and a 32-bit memory word:
// store byte-enables and write replication, load lane extraction and
// sign/zero extension, and alignment checking.
// Byte/half support is built only when MEM_ARBITER_SUBWORD_EN is defined;
// otherwise every access is treated as a full word.
module mem_lane
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic        uns_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

`ifdef MEM_ARBITER_SUBWORD_EN
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword lanes out of the raw read word
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            default: byte_s = rdata_i[31:24];
        endcase
        if (addr_lo_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
    end

    // Per-width enables, replication, extension and alignment check
    always_comb begin
        be_o         = 4'hF;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = 1'b0;
        case (width_i)
            W_BYTE: begin
                be_o         = 4'b0001 << addr_lo_i;
                wdata_o      = {4{wdata_i[7:0]}};
                rdata_o      = {{24{~uns_i & byte_s[7]}}, byte_s};
                misaligned_o = 1'b0;
            end
            W_HALF: begin
                be_o         = 4'b0011 << addr_lo_i;
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = {{16{~uns_i & half_s[15]}}, half_s};
                misaligned_o = addr_lo_i[0];
            end
            default: begin
                misaligned_o = (addr_lo_i != 2'b00);
            end
        endcase
    end
`else
    logic unused_s;
    assign unused_s = ^{width_i, uns_i};

    // Word-only accesses: full enables, pass-through data, any low bit misaligns
    always_comb begin
        be_o         = 4'hF;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = (addr_lo_i != 2'b00);
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and
// load/store (D). One outstanding transaction; D has priority except that
// after D_STREAK_MAX consecutive D grants with I waiting, I is forced to win.
// Optional sub-word lanes: define MEM_ARBITER_SUBWORD_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int D_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [31:0]       i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [1:0]        d_width_i,
    input  logic              d_uns_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              d_err_o,
    output logic              m_req_o,
    input  logic              m_gnt_i,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [3:0]        m_be_o,
    output logic [31:0]       m_wdata_o,
    input  logic              m_rvalid_i,
    input  logic [31:0]       m_rdata_i
);

    localparam logic [3:0] STREAK_MAX = 4'(D_STREAK_MAX);

    state_e            state_q;
    logic [3:0]        streak_q, streak_d;
    logic              owner_q, uns_q;
    logic [1:0]        width_q, addr_lo_q;
    logic              m_req_q, m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [3:0]        m_be_q;
    logic [31:0]       m_wdata_q, i_rdata_q, d_rdata_q;
    logic              i_rvalid_q, d_rvalid_q, d_err_q;

    logic              i_gnt_s, d_gnt_s;
    logic [1:0]        lane_width_s, lane_addr_s;
    logic              lane_uns_s, lane_mis_s;
    logic [3:0]        lane_be_s;
    logic [31:0]       lane_wdata_s, lane_rdata_s;
    logic              unused_s;

    assign unused_s = ^i_addr_i[1:0];

    // Arbitration: only in IDLE, D first unless I has waited a full streak
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if ((state_q == ST_IDLE) && rst_n) begin
            if (d_req_i && !(i_req_i && (streak_q == STREAK_MAX))) begin
                d_gnt_s = 1'b1;
            end else if (i_req_i) begin
                i_gnt_s = 1'b1;
            end else begin
                i_gnt_s = 1'b0;
            end
        end else begin
            d_gnt_s = 1'b0;
        end
    end

    // Next streak count: grows on D grants that keep I waiting, saturating
    always_comb begin
        streak_d = streak_q;
        if (d_gnt_s) begin
            if (!i_req_i) begin
                streak_d = 4'd0;
            end else if (streak_q == STREAK_MAX) begin
                streak_d = streak_q;
            end else begin
                streak_d = streak_q + 4'd1;
            end
        end else if (i_gnt_s) begin
            streak_d = 4'd0;
        end else begin
            streak_d = streak_q;
        end
    end

    // Lane logic sees live request fields while arbitrating, captured ones after
    always_comb begin
        if (state_q == ST_IDLE) begin
            lane_width_s = d_width_i;
            lane_uns_s   = d_uns_i;
            lane_addr_s  = d_addr_i[1:0];
        end else begin
            lane_width_s = width_q;
            lane_uns_s   = uns_q;
            lane_addr_s  = addr_lo_q;
        end
    end

    mem_lane u_lane (
        .width_i      (lane_width_s),
        .uns_i        (lane_uns_s),
        .addr_lo_i    (lane_addr_s),
        .wdata_i      (d_wdata_i),
        .rdata_i      (m_rdata_i),
        .be_o         (lane_be_s),
        .wdata_o      (lane_wdata_s),
        .rdata_o      (lane_rdata_s),
        .misaligned_o (lane_mis_s)
    );

    // Transaction sequencer with registered memory-side and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            streak_q   <= 4'd0;
            owner_q    <= OWN_I;
            uns_q      <= 1'b0;
            width_q    <= W_WORD;
            addr_lo_q  <= 2'b00;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_be_q     <= 4'h0;
            m_wdata_q  <= 32'h0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= 32'h0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= 32'h0;
            d_err_q    <= 1'b0;
        end else begin
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= 32'h0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= 32'h0;
            d_err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    streak_q <= streak_d;
                    if (d_gnt_s) begin
                        owner_q   <= OWN_D;
                        width_q   <= d_width_i;
                        uns_q     <= d_uns_i;
                        addr_lo_q <= d_addr_i[1:0];
                        m_we_q    <= d_we_i;
                        m_addr_q  <= {d_addr_i[ADDR_W-1:2], 2'b00};
                        m_be_q    <= d_we_i ? lane_be_s : 4'hF;
                        m_wdata_q <= d_we_i ? lane_wdata_s : 32'h0;
                        if (lane_mis_s) begin
                            state_q    <= ST_ERR;
                            d_rvalid_q <= 1'b1;
                            d_err_q    <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                            m_req_q <= 1'b1;
                        end
                    end else if (i_gnt_s) begin
                        owner_q   <= OWN_I;
                        width_q   <= W_WORD;
                        uns_q     <= 1'b0;
                        addr_lo_q <= 2'b00;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= {i_addr_i[ADDR_W-1:2], 2'b00};
                        m_be_q    <= 4'hF;
                        m_wdata_q <= 32'h0;
                        m_req_q   <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (m_gnt_i) begin
                        m_req_q <= 1'b0;
                        state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (m_rvalid_i) begin
                        state_q <= ST_RESP;
                        if (owner_q == OWN_I) begin
                            i_rvalid_q <= 1'b1;
                            i_rdata_q  <= m_rdata_i;
                        end else begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= m_we_q ? 32'h0 : lane_rdata_s;
                        end
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign i_gnt_o    = i_gnt_s;
    assign d_gnt_o    = d_gnt_s;
    assign i_rvalid_o = i_rvalid_q;
    assign i_rdata_o  = i_rdata_q;
    assign d_rvalid_o = d_rvalid_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_err_o    = d_err_q;
    assign m_req_o    = m_req_q;
    assign m_we_o     = m_we_q;
    assign m_addr_o   = m_addr_q;
    assign m_be_o     = m_be_q;
    assign m_wdata_o  = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Per-cycle expectations come from a
// transaction-level model of the access rules; a single compare process
// checks every output at each falling edge. Follows MEM_ARBITER_SUBWORD_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_uns = 1'b0;
    logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic [1:0]  d_width = 2'b10;
    logic        m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, m_req, m_we;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_be;

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;

    // expected outputs for the current cycle
    logic        e_i_gnt, e_d_gnt, e_i_rv, e_d_rv, e_d_err, e_m_req, e_m_we;
    logic [31:0] e_i_rd, e_d_rd, e_m_addr, e_m_wd;
    logic [3:0]  e_m_be;

    // last values seen, for literal pinning checks
    logic [31:0] last_i_rd, last_d_rd, last_m_addr, last_m_wd;
    logic [3:0]  last_m_be;
    logic        last_d_err, seen_m_req;

    mem_arbiter #(.ADDR_W(32), .D_STREAK_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
        .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_width_i(d_width),
        .d_uns_i(d_uns), .d_wdata_i(d_wdata), .d_gnt_o(d_gnt),
        .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
        .m_req_o(m_req), .m_gnt_i(m_gnt), .m_we_o(m_we), .m_addr_o(m_addr),
        .m_be_o(m_be), .m_wdata_o(m_wdata), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- access-rule model ----------------
    function automatic int nbytes(input logic [1:0] w);
`ifdef MEM_ARBITER_SUBWORD_EN
        if (w == 2'b00) return 1;
        if (w == 2'b01) return 2;
`endif
        return 4;
    endfunction

    function automatic logic model_mis(input logic [1:0] w, input logic [31:0] a);
        int off = int'(a[1:0]);
        return (off % nbytes(w)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] w, input logic [31:0] a);
        int nb = nbytes(w);
        int v = ((1 << nb) - 1) << int'(a[1:0]);
        return 4'(v);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] d);
        int nb = nbytes(w);
        if (nb == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (nb == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] w, input logic u,
                                               input logic [31:0] a, input logic [31:0] raw);
        int nb = nbytes(w);
        logic [31:0] mask, v;
        if (nb == 4) return raw;
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v = (raw >> (8 * int'(a[1:0]))) & mask;
        if (!u && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("i_gnt", 32'(i_gnt), 32'(e_i_gnt));
            chk("d_gnt", 32'(d_gnt), 32'(e_d_gnt));
            chk("i_rvalid", 32'(i_rvalid), 32'(e_i_rv));
            chk("d_rvalid", 32'(d_rvalid), 32'(e_d_rv));
            chk("m_req", 32'(m_req), 32'(e_m_req));
            if (e_i_rv) chk("i_rdata", i_rdata, e_i_rd);
            if (e_d_rv) begin
                chk("d_rdata", d_rdata, e_d_rd);
                chk("d_err", 32'(d_err), 32'(e_d_err));
            end
            if (e_m_req) begin
                chk("m_we", 32'(m_we), 32'(e_m_we));
                chk("m_addr", m_addr, e_m_addr);
                chk("m_be", 32'(m_be), 32'(e_m_be));
                if (e_m_we) chk("m_wdata", m_wdata, e_m_wd);
            end
        end
        if (i_rvalid) last_i_rd = i_rdata;
        if (d_rvalid) begin
            last_d_rd  = d_rdata;
            last_d_err = d_err;
        end
        if (m_req) begin
            seen_m_req  = 1'b1;
            last_m_addr = m_addr;
            last_m_be   = m_be;
            last_m_wd   = m_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        e_i_gnt = 1'b0; e_d_gnt = 1'b0; e_i_rv = 1'b0; e_d_rv = 1'b0; e_d_err = 1'b0;
        e_m_req = 1'b0; e_m_we = 1'b0; e_i_rd = 32'h0; e_d_rd = 32'h0;
        e_m_addr = 32'h0; e_m_wd = 32'h0; e_m_be = 4'h0;
    endtask

    task automatic clear_last();
        last_i_rd = 32'hDEAD_0001; last_d_rd = 32'hDEAD_0002; last_m_addr = 32'hDEAD_0003;
        last_m_wd = 32'hDEAD_0004; last_m_be = 4'h0; last_d_err = 1'bx; seen_m_req = 1'b0;
    endtask

    task automatic i_txn(input logic [31:0] addr, input logic [31:0] raw);
        clear_last();
        step();
        i_req = 1'b1; i_addr = addr;
        clear_exp(); e_i_gnt = 1'b1;
        step();
        i_req = 1'b0; clear_exp();
        e_m_req = 1'b1; e_m_addr = {addr[31:2], 2'b00}; e_m_be = 4'hF;
        m_gnt = 1'b1;
        step();
        m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = raw; clear_exp();
        step();
        m_rvalid = 1'b0; clear_exp(); e_i_rv = 1'b1; e_i_rd = raw;
        step();
        clear_exp();
    endtask

    task automatic d_txn(input logic we, input logic [31:0] addr, input logic [1:0] width,
                         input logic uns, input logic [31:0] wdata, input logic [31:0] raw,
                         input int stall, input logic stall_ireq);
        clear_last();
        step();
        d_req = 1'b1; d_we = we; d_addr = addr; d_width = width; d_uns = uns; d_wdata = wdata;
        clear_exp(); e_d_gnt = 1'b1;
        step();
        d_req = 1'b0; clear_exp();
        if (model_mis(width, addr)) begin
            e_d_rv = 1'b1; e_d_err = 1'b1; e_d_rd = 32'h0;
            step();
            clear_exp();
        end else begin
            e_m_req = 1'b1; e_m_we = we; e_m_addr = {addr[31:2], 2'b00};
            e_m_be = we ? model_be(width, addr) : 4'hF;
            e_m_wd = model_wdata(width, wdata);
            for (int s = 0; s < stall; s++) begin
                i_req = stall_ireq; i_addr = 32'h0040_0040;
                step();
            end
            i_req = 1'b0; m_gnt = 1'b1;
            step();
            m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = raw; clear_exp();
            step();
            m_rvalid = 1'b0; clear_exp();
            e_d_rv = 1'b1; e_d_err = 1'b0;
            e_d_rd = we ? 32'h0 : model_load(width, uns, addr, raw);
            step();
            clear_exp();
        end
    endtask

    initial begin
        clear_exp();
        clear_last();
        #3;
        chk("rst_m_req", 32'(m_req), 32'h0);
        chk("rst_m_be", 32'(m_be), 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_rvalid", 32'({i_rvalid, d_rvalid, d_err}), 32'h0);
        chk("rst_rdata", i_rdata | d_rdata, 32'h0);
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;

        // instruction fetch
        i_txn(32'h0040_0008, 32'h00A0_0093);
        chk("fetch_m_addr", last_m_addr, 32'h0040_0008);
        chk("fetch_rdata", last_i_rd, 32'h00A0_0093);

        // store byte, then signed and unsigned byte loads at the same address
        d_txn(1'b1, 32'h1001_0003, 2'b00, 1'b0, 32'h0000_00AB, 32'h0, 0, 1'b0);
`ifdef MEM_ARBITER_SUBWORD_EN
        chk("sb_m_be", 32'(last_m_be), 32'h8);
        chk("sb_m_wdata", last_m_wd, 32'hABAB_ABAB);
        chk("sb_err", 32'(last_d_err), 32'h0);
`else
        chk("sb_err", 32'(last_d_err), 32'h1);
`endif
        d_txn(1'b0, 32'h1001_0003, 2'b00, 1'b0, 32'h0, 32'hAB12_3456, 0, 1'b0);
`ifdef MEM_ARBITER_SUBWORD_EN
        chk("lb_signed", last_d_rd, 32'hFFFF_FFAB);
`else
        chk("lb_err", 32'(last_d_err), 32'h1);
`endif
        d_txn(1'b0, 32'h1001_0003, 2'b00, 1'b1, 32'h0, 32'hAB12_3456, 0, 1'b0);
`ifdef MEM_ARBITER_SUBWORD_EN
        chk("lbu", last_d_rd, 32'h0000_00AB);
`else
        chk("lbu_err", 32'(last_d_err), 32'h1);
`endif

        // misaligned half: error, no memory cycle
        d_txn(1'b0, 32'h1001_0001, 2'b01, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        chk("mis_half_err", 32'(last_d_err), 32'h1);
        chk("mis_no_mreq", 32'(seen_m_req), 32'h0);

        // word store stalled 5 cycles in ISSUE with I knocking
        d_txn(1'b1, 32'h1001_0010, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 5, 1'b1);
        chk("stall_wdata", last_m_wd, 32'hDEAD_BEEF);
        chk("stall_be", 32'(last_m_be), 32'hF);

        // more lane patterns
        d_txn(1'b0, 32'h1001_0002, 2'b01, 1'b0, 32'h0, 32'h8001_7FFF, 0, 1'b0);
        d_txn(1'b1, 32'h1001_0002, 2'b01, 1'b0, 32'h0000_1234, 32'h0, 0, 1'b0);
        d_txn(1'b0, 32'h1001_0004, 2'b11, 1'b0, 32'h0, 32'h89AB_CDEF, 0, 1'b0);
        chk("lw_w11", last_d_rd, 32'h89AB_CDEF);
        d_txn(1'b0, 32'h1001_0001, 2'b00, 1'b1, 32'h0, 32'h0000_8000, 0, 1'b0);
        d_txn(1'b0, 32'h1001_0006, 2'b10, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        chk("mis_word_err", 32'(last_d_err), 32'h1);

        // both held: grant order D,D,D,D,I repeating
        step();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_width = 2'b10; d_uns = 1'b0;
        d_addr = 32'h1001_0020; i_addr = 32'h0040_0100;
        for (int k = 0; k < 10; k++) begin
            clear_exp();
            e_i_gnt = ((k % 5) == 4);
            e_d_gnt = !e_i_gnt;
            step();
            clear_exp();
            e_m_req = 1'b1; e_m_be = 4'hF;
            e_m_addr = ((k % 5) == 4) ? 32'h0040_0100 : 32'h1001_0020;
            m_gnt = 1'b1;
            step();
            m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hC0DE_0000 + k; clear_exp();
            step();
            m_rvalid = 1'b0; clear_exp();
            if ((k % 5) == 4) begin
                e_i_rv = 1'b1; e_i_rd = 32'hC0DE_0000 + k;
            end else begin
                e_d_rv = 1'b1; e_d_rd = 32'hC0DE_0000 + k;
            end
            if (k == 9) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            step();
        end
        clear_exp();

        // reset while waiting for the memory response
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0040; d_width = 2'b10;
        e_d_gnt = 1'b1;
        step();
        d_req = 1'b0; clear_exp();
        e_m_req = 1'b1; e_m_addr = 32'h1001_0040; e_m_be = 4'hF;
        m_gnt = 1'b1;
        step();
        m_gnt = 1'b0; clear_exp();
        rst_n = 1'b0;
        #1;
        chk("rstw_m_req", 32'(m_req), 32'h0);
        chk("rstw_m_addr", m_addr, 32'h0);
        chk("rstw_m_be", 32'(m_be), 32'h0);
        chk("rstw_m_wdata", m_wdata, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
        step();
        m_rvalid = 1'b0;
        step();

        // recovery after reset
        i_txn(32'h0040_0010, 32'h0000_0013);
        chk("post_rst_fetch", last_i_rd, 32'h0000_0013);

        step();
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
